// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder
// Brief    : Word-addressed RAM responder for memRead/memWrite strobes.
//            Each rising strobe becomes one access. The access completes after
//            WAIT_CYCLES wait states plus one access cycle, and completion is
//            signalled with a one-cycle mem_ready pulse.
//            Optional build macro MEM_ERR_EN adds a range check and an error
//            pulse on mem_err.
// Revision : 1.0 - initial release
// ============================================================================
module mem_responder #(
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 512,   // power of two, <= 2**ADDR_W
  parameter int WAIT_CYCLES = 1      // 0..15
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              mem_busy,
  output logic              mem_ready,
  output logic              mem_err
);

  localparam int         IDX_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] c_WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_req_q;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_is_read;
  logic [3:0]          r_cnt;
  logic [DATA_W-1:0]   r_data_out;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_strobe;
  logic                w_req_edge;
  logic                w_accept;
  logic [IDX_W-1:0]    w_idx;
  logic                w_addr_ok;
  logic                w_rd_en;
  logic                w_wr_en;

  assign w_strobe   = memRead | memWrite;
  assign w_req_edge = w_strobe & ~r_req_q;
  assign w_accept   = (r_state == S_IDLE) & w_req_edge;
  assign w_idx      = r_addr[IDX_W-1:0];

`ifdef MEM_ERR_EN
  localparam logic [ADDR_W:0] c_DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
  logic r_mem_err;

  assign w_addr_ok = ({1'b0, r_addr} < c_DEPTH_EXT);

  // Error pulse: out-of-range access (lands in DONE) or request dropped while busy.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_mem_err <= 1'b0;
    end else begin
      r_mem_err <= ((r_state == S_ACCESS) & ~w_addr_ok) |
                   ((r_state != S_IDLE) & w_req_edge);
    end
  end

  assign mem_err = r_mem_err;
`else
  // Address wraps modulo DEPTH; the high address bits are intentionally ignored.
  assign w_addr_ok = 1'b1;
  assign mem_err   = 1'b0;

  if (IDX_W < ADDR_W) begin : g_addr_hi
    logic w_unused_addr_hi;
    assign w_unused_addr_hi = |r_addr[ADDR_W-1:IDX_W];
  end
`endif

  // A write commits only in ACCESS and never in a cycle where clr is asserted.
  assign w_rd_en = (r_state == S_ACCESS) & r_is_read;
  assign w_wr_en = (r_state == S_ACCESS) & ~r_is_read & w_addr_ok & ~clr;

  // State register.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and status outputs.
  always_comb begin
    w_state_nxt = r_state;
    mem_busy    = 1'b0;
    mem_ready   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
        end
      end
      S_WAIT: begin
        mem_busy = 1'b1;
        if (r_cnt == 4'd0) begin
          w_state_nxt = S_ACCESS;
        end
      end
      S_ACCESS: begin
        mem_busy    = 1'b1;
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        mem_busy    = 1'b1;
        mem_ready   = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Edge detector, request capture and wait-state counter.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_req_q   <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_is_read <= 1'b0;
      r_cnt     <= 4'd0;
    end else begin
      r_req_q <= w_strobe;
      if (w_accept) begin
        r_addr    <= address;
        r_wdata   <= data_in;
        r_is_read <= memRead;   // read wins when both strobes are high
        r_cnt     <= c_WAIT_LOAD;
      end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  // Read data register: holds the last completed read.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_data_out <= '0;
    end else if (w_rd_en) begin
      r_data_out <= w_addr_ok ? r_mem[w_idx] : '0;
    end
  end

  // RAM write port; contents survive clr.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_idx] <= r_wdata;
    end
  end

  assign data_out = r_data_out;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_responder
// Brief    : Directed self-checking bench for mem_responder. Several DUT
//            copies with different WAIT_CYCLES / DEPTH share one stimulus bus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        clr;
  logic        memRead;
  logic        memWrite;
  logic [8:0]  address;
  logic [31:0] data_in;

  logic [31:0] dout_w1, dout_w0, dout_w3, dout_w2, dout_d256;
  logic        busy_w1, busy_w0, busy_w3, busy_w2, busy_d256;
  logic        rdy_w1,  rdy_w0,  rdy_w3,  rdy_w2,  rdy_d256;
  logic        err_w1,  err_w0,  err_w3,  err_w2,  err_d256;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_responder #(.WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .clr(clr), .memRead(memRead), .memWrite(memWrite),
    .address(address), .data_in(data_in), .data_out(dout_w1),
    .mem_busy(busy_w1), .mem_ready(rdy_w1), .mem_err(err_w1));

  mem_responder #(.WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .clr(clr), .memRead(memRead), .memWrite(memWrite),
    .address(address), .data_in(data_in), .data_out(dout_w0),
    .mem_busy(busy_w0), .mem_ready(rdy_w0), .mem_err(err_w0));

  mem_responder #(.WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .clr(clr), .memRead(memRead), .memWrite(memWrite),
    .address(address), .data_in(data_in), .data_out(dout_w3),
    .mem_busy(busy_w3), .mem_ready(rdy_w3), .mem_err(err_w3));

  mem_responder #(.WAIT_CYCLES(2)) u_w2 (
    .clk(clk), .clr(clr), .memRead(memRead), .memWrite(memWrite),
    .address(address), .data_in(data_in), .data_out(dout_w2),
    .mem_busy(busy_w2), .mem_ready(rdy_w2), .mem_err(err_w2));

  mem_responder #(.DEPTH(256), .WAIT_CYCLES(1)) u_d256 (
    .clk(clk), .clr(clr), .memRead(memRead), .memWrite(memWrite),
    .address(address), .data_in(data_in), .data_out(dout_d256),
    .mem_busy(busy_d256), .mem_ready(rdy_d256), .mem_err(err_d256));

`ifdef MEM_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  // One clock, observed 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_n(input int n);
    repeat (n) step();
  endtask

  task automatic write_word(input logic [8:0] a, input logic [31:0] d);
    memWrite = 1'b1; address = a; data_in = d;
    step();
    memWrite = 1'b0;
    step_n(7);
  endtask

  task automatic read_word(input logic [8:0] a);
    memRead = 1'b1; address = a;
    step();
    memRead = 1'b0;
    step_n(7);
  endtask

  task automatic test_reset();
    clr = 1'b1;
    step_n(3);
    vectors++;
    if ({busy_w1, rdy_w1, err_w1} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_flags: got busy/ready/err=%b expected 000", {busy_w1, rdy_w1, err_w1});
    end
    vectors++;
    if (dout_w1 !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_dout: got %h expected 00000000", dout_w1);
    end
    clr = 1'b0;
    step();
  endtask

  task automatic test_write_read();
    write_word(9'h005, 32'hDEADBEEF);
    memRead = 1'b1; address = 9'h005;
    step();
    memRead = 1'b0;
    vectors++;
    if ({busy_w1, rdy_w1} !== 2'b10) begin
      miscompares++;
      $display("FAIL wr_rd_c1: got busy/ready=%b expected 10", {busy_w1, rdy_w1});
    end
    step();
    vectors++;
    if (rdy_w1 !== 1'b0) begin
      miscompares++;
      $display("FAIL wr_rd_c2_ready: got %b expected 0", rdy_w1);
    end
    step();
    vectors++;
    if ({busy_w1, rdy_w1} !== 2'b11) begin
      miscompares++;
      $display("FAIL wr_rd_c3: got busy/ready=%b expected 11", {busy_w1, rdy_w1});
    end
    vectors++;
    if (dout_w1 !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL wr_rd_data: got %h expected deadbeef", dout_w1);
    end
    step();
    vectors++;
    if ({busy_w1, rdy_w1} !== 2'b00) begin
      miscompares++;
      $display("FAIL wr_rd_c4: got busy/ready=%b expected 00", {busy_w1, rdy_w1});
    end
    step_n(5);
  endtask

  task automatic test_latency();
    int busy0 = 0, busy3 = 0, rcnt0 = 0, rcnt3 = 0, rpos0 = -1, rpos3 = -1;
    memRead = 1'b1; address = 9'h005;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 1) memRead = 1'b0;
      if (busy_w0) busy0++;
      if (busy_w3) busy3++;
      if (rdy_w0) begin rcnt0++; rpos0 = k; end
      if (rdy_w3) begin rcnt3++; rpos3 = k; end
    end
    vectors++;
    if (rpos0 != 2 || rcnt0 != 1) begin
      miscompares++;
      $display("FAIL lat_w0_ready: got pos %0d count %0d expected pos 2 count 1", rpos0, rcnt0);
    end
    vectors++;
    if (busy0 != 2) begin
      miscompares++;
      $display("FAIL lat_w0_busy: got %0d cycles expected 2", busy0);
    end
    vectors++;
    if (rpos3 != 5 || rcnt3 != 1) begin
      miscompares++;
      $display("FAIL lat_w3_ready: got pos %0d count %0d expected pos 5 count 1", rpos3, rcnt3);
    end
    vectors++;
    if (busy3 != 5) begin
      miscompares++;
      $display("FAIL lat_w3_busy: got %0d cycles expected 5", busy3);
    end
    vectors++;
    if (dout_w3 !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL lat_w3_data: got %h expected deadbeef", dout_w3);
    end
  endtask

  task automatic test_held_strobe();
    int rcnt = 0, ecnt = 0;
    memRead = 1'b1; address = 9'h005;
    for (int k = 1; k <= 14; k++) begin
      step();
      if (k == 8) memRead = 1'b0;
      if (rdy_w1) rcnt++;
      if (err_w1) ecnt++;
    end
    vectors++;
    if (rcnt != 1) begin
      miscompares++;
      $display("FAIL held_ready_count: got %0d expected 1", rcnt);
    end
    vectors++;
    if (ecnt != 0) begin
      miscompares++;
      $display("FAIL held_err_count: got %0d expected 0", ecnt);
    end
  endtask

  task automatic test_simultaneous();
    write_word(9'h007, 32'h00000011);
    memRead = 1'b1; memWrite = 1'b1; address = 9'h007; data_in = 32'h00000022;
    step();
    memRead = 1'b0; memWrite = 1'b0;
    step_n(2);
    vectors++;
    if (rdy_w1 !== 1'b1 || dout_w1 !== 32'h00000011) begin
      miscompares++;
      $display("FAIL both_strobes_read: got ready %b data %h expected 1 00000011", rdy_w1, dout_w1);
    end
    step_n(5);
    write_word(9'h005, 32'h00000099);   // disturb data_out path with a different address
    read_word(9'h007);
    vectors++;
    if (dout_w1 !== 32'h00000011) begin
      miscompares++;
      $display("FAIL both_strobes_ram: got %h expected 00000011", dout_w1);
    end
    write_word(9'h005, 32'hDEADBEEF);
  endtask

  task automatic test_reset_mid_write();
    write_word(9'h003, 32'h00000055);
    memWrite = 1'b1; address = 9'h003; data_in = 32'h000000AA;
    step();                              // W=2 copy now in WAIT, W=0 copy in ACCESS
    memWrite = 1'b0;
    clr = 1'b1;
    step();
    clr = 1'b0;
    vectors++;
    if ({busy_w2, rdy_w2, err_w2} !== 3'b000 || dout_w2 !== 32'h0) begin
      miscompares++;
      $display("FAIL clr_outputs: got flags %b data %h expected 000 00000000",
               {busy_w2, rdy_w2, err_w2}, dout_w2);
    end
    step();
    vectors++;
    if (busy_w2 !== 1'b0) begin
      miscompares++;
      $display("FAIL clr_no_restart: got busy %b expected 0", busy_w2);
    end
    step_n(4);
    read_word(9'h003);
    vectors++;
    if (dout_w2 !== 32'h00000055) begin
      miscompares++;
      $display("FAIL clr_wait_abort: got %h expected 00000055", dout_w2);
    end
    vectors++;
    if (dout_w0 !== 32'h00000055) begin
      miscompares++;
      $display("FAIL clr_access_abort: got %h expected 00000055", dout_w0);
    end
  endtask

  task automatic test_reset_held_strobe();
    memRead = 1'b1; address = 9'h005;
    clr = 1'b1;
    step_n(2);
    clr = 1'b0;
    step();
    vectors++;
    if (busy_w1 !== 1'b1) begin
      miscompares++;
      $display("FAIL post_clr_accept: got busy %b expected 1", busy_w1);
    end
    step_n(2);
    vectors++;
    if (rdy_w1 !== 1'b1 || dout_w1 !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL post_clr_read: got ready %b data %h expected 1 deadbeef", rdy_w1, dout_w1);
    end
    memRead = 1'b0;
    step_n(6);
  endtask

  task automatic test_dropped();
    int extra = 0;
    memRead = 1'b1; address = 9'h005;
    step();
    memRead = 1'b0;
    step();                              // W=1 copy in ACCESS
    memRead = 1'b1;
    step();                              // edge seen while busy
    vectors++;
    if (rdy_w1 !== 1'b1 || err_w1 !== ERR_EXP) begin
      miscompares++;
      $display("FAIL drop_err: got ready %b err %b expected 1 %b", rdy_w1, err_w1, ERR_EXP);
    end
    memRead = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (rdy_w1 || err_w1) extra++;
    end
    vectors++;
    if (extra != 0) begin
      miscompares++;
      $display("FAIL drop_no_queue: got %0d extra pulses expected 0", extra);
    end
  endtask

  task automatic test_wrap();
    write_word(9'h0F0, 32'hCAFEF00D);
    memRead = 1'b1; address = 9'h1F0;
    step();
    memRead = 1'b0;
    step_n(2);
`ifdef MEM_ERR_EN
    vectors++;
    if (rdy_d256 !== 1'b1 || err_d256 !== 1'b1 || dout_d256 !== 32'h0) begin
      miscompares++;
      $display("FAIL oob_read: got ready %b err %b data %h expected 1 1 00000000",
               rdy_d256, err_d256, dout_d256);
    end
`else
    vectors++;
    if (rdy_d256 !== 1'b1 || err_d256 !== 1'b0 || dout_d256 !== 32'hCAFEF00D) begin
      miscompares++;
      $display("FAIL wrap_read: got ready %b err %b data %h expected 1 0 cafef00d",
               rdy_d256, err_d256, dout_d256);
    end
`endif
    step_n(6);
  endtask

  initial begin
    clr = 1'b1; memRead = 1'b0; memWrite = 1'b0; address = '0; data_in = '0;
    test_reset();
    test_write_read();
    test_latency();
    test_held_strobe();
    test_simultaneous();
    test_reset_mid_write();
    test_reset_held_strobe();
    test_dropped();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
